// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Circular prefetch FIFO of fetch entries; flush empties it in one cycle.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC register driving the IM port, prefetch buffer toward ID.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Instr_addr,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      pc;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     new_entry;
    logic             push;
    logic             pop;
    logic             buf_full;

    assign id_valid  = (buf_count != '0);
    assign buf_full  = (buf_count == DEPTH_C);
    assign pop       = id_valid & id_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign push      = ~redirect_valid & (~buf_full | pop);
    assign new_entry = '{pc: pc, instr: Instruction};

    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (new_entry),
        .head     (buf_head),
        .count    (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            if (redirect_valid) pc <= redirect_pc & PC_ALIGN_MASK;
            else if (push)      pc <= pc + 32'(INSTR_BYTES);
            if (push) fetch_count <= fetch_count + 32'd1;
        end
    end

    assign Instr_addr  = pc;
    assign id_instr    = id_valid ? buf_head.instr : '0;
    assign id_pc       = id_valid ? buf_head.pc : '0;
    assign id_pc_plus4 = id_valid ? (buf_head.pc + 32'(INSTR_BYTES)) : '0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit against a queue-level fetch model.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr_addr, Instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

    logic [31:0] addr2, instr2;
    logic        valid2;
    logic [31:0] id_instr2, id_pc2, id_plus4_2, fc2;
    logic        ready2 = 1'b1;
    logic        redir2 = 1'b0;
    logic [31:0] rpc2   = 32'h0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb Instruction = im_word(Instr_addr);
    always_comb instr2      = im_word(addr2);

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .Instr_addr(Instr_addr), .Instruction(Instruction),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .fetch_count(fetch_count)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .Instr_addr(addr2), .Instruction(instr2),
        .redirect_valid(redir2), .redirect_pc(rpc2), .id_ready(ready2),
        .id_valid(valid2), .id_instr(id_instr2), .id_pc(id_pc2),
        .id_pc_plus4(id_plus4_2), .fetch_count(fc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched {pc, instr} pairs awaiting delivery.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc.delete();
            q_instr.delete();
            m_pc = 32'h0;
            m_fc = 32'h0;
        end else if (redirect_valid) begin
            q_pc.delete();
            q_instr.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (id_ready && q_pc.size() != 0) begin
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (q_pc.size() < DEPTH) begin
                q_pc.push_back(m_pc);
                q_instr.push_back(im_word(m_pc));
                m_pc = m_pc + 32'd4;
                m_fc = m_fc + 32'd1;
            end
        end
    end

    // Monitor: compare presented head against scoreboard front every cycle.
    always @(negedge clk) begin
        chk("id_valid", {31'b0, id_valid}, {31'b0, q_pc.size() != 0});
        if (q_pc.size() != 0) begin
            chk("id_pc", id_pc, q_pc[0]);
            chk("id_instr", id_instr, q_instr[0]);
            chk("id_pc_plus4", id_pc_plus4, q_pc[0] + 32'd4);
        end else begin
            chk("empty_pc", id_pc, 32'h0);
            chk("empty_instr", id_instr, 32'h0);
            chk("empty_plus4", id_pc_plus4, 32'h0);
        end
        chk("instr_addr", Instr_addr, m_pc);
        chk("fetch_count", fetch_count, m_fc);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_fc", fetch_count, 32'h0);
        chk("rst_addr", Instr_addr, 32'h0);
        rst_n = 1'b1;

        // Stall: exactly DEPTH pushes, pc parks at 8, head stays at 0.
        repeat (5) begin
            cyc();
        end
        chk("stall_addr", Instr_addr, 32'h8);
        chk("stall_fc", fetch_count, 32'd2);
        chk("stall_head", id_pc, 32'h0);

        // Wrap-around instance ran freely since release.
        chk("wrap_fc", fc2, 32'd5);

        // Full buffer with pop: push still happens.
        id_ready = 1'b1;
        cyc();
        chk("fullpop_addr", Instr_addr, 32'hC);
        chk("fullpop_fc", fetch_count, 32'd3);
        chk("fullpop_head", id_pc, 32'h4);
        repeat (3) cyc();

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, id_valid}, 32'h0);
        chk("redir_addr", Instr_addr, 32'h100);
        cyc();
        chk("redir_head", id_pc, 32'h100);
        repeat (2) cyc();

        // Back-to-back redirects: last wins, nothing pushed between.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cyc();
        redirect_pc    = 32'h0000_0306;
        cyc();
        redirect_valid = 1'b0;
        chk("b2b_addr", Instr_addr, 32'h304);
        chk("b2b_valid", {31'b0, id_valid}, 32'h0);
        cyc();
        chk("b2b_head", id_pc, 32'h304);

        for (int n = 0; n < 500; n++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : $urandom;
            cyc();
        end
        redirect_valid = 1'b0;

        // Fill the buffer, then reset mid-stream.
        id_ready = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, id_valid}, 32'h0);
        chk("midrst_fc", fetch_count, 32'h0);
        chk("midrst_addr", Instr_addr, 32'h0);
        chk("midrst_wrap_addr", addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        id_ready = 1'b1;

        // Restart: one instruction per cycle; wrap instance crosses zero.
        cyc();
        chk("restart_pc0", id_pc, 32'h0);
        chk("wrap_pc0", id_pc2, 32'hFFFF_FFF8);
        cyc();
        chk("restart_pc1", id_pc, 32'h4);
        chk("wrap_pc1", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4_1", id_plus4_2, 32'h0);
        cyc();
        chk("restart_pc2", id_pc, 32'h8);
        chk("wrap_pc2", id_pc2, 32'h0);
        chk("wrap_plus4_2", id_plus4_2, 32'h4);
        chk("wrap_instr2", id_instr2, im_word(32'h0));
        repeat (5) cyc();
        chk("restart_fc", fetch_count, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
